imem_port_arbiter: RTL and testbench
====================================

Name: imem_port_arbiter

Overview:
- Shares the single-port instruction memory between two requesters: the core fetch unit (read-only) and the debug/program-loader port (read/write).
- Drives the RAM's address, write-enable, byte-enable and write-data inputs; the RAM returns read data one cycle after the address.
- Routes each registered read response back to the requester that issued it.
- Provides a lock mode that lets the loader own the memory exclusively while it rewrites the program.

Parameters:
IMEM_ADDR_WIDTH, 14, byte-address width of the memory port.
FAIR_LIMIT, 4, maximum consecutive debug grants while fetch is waiting; fetch then wins one cycle (SHARED state only).

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_f_req  in  1  fetch request valid
i_f_addr  in  IMEM_ADDR_WIDTH  fetch byte address (unaligned allowed)
o_f_gnt  out  1  fetch request accepted this cycle
i_f_flush  in  1  discard any fetch response due next cycle
o_f_rvalid  out  1  fetch response valid
o_f_rdata  out  32  fetch response data
i_d_req  in  1  debug request valid
i_d_we  in  1  debug write
i_d_be  in  4  debug byte enables
i_d_addr  in  IMEM_ADDR_WIDTH  debug byte address
i_d_wdata  in  32  debug write data
o_d_gnt  out  1  debug request accepted
o_d_rvalid  out  1  debug response valid (read data or write ack)
o_d_rdata  out  32  debug read data; 0 on write ack
o_d_err  out  1  qualifies o_d_rvalid: unaligned write rejected
i_d_lock  in  1  debug requests exclusive ownership
o_locked  out  1  high in LOCKED state
o_mem_addr  out  IMEM_ADDR_WIDTH  to RAM address
o_mem_we  out  1  to RAM write enable
o_mem_size  out  4  to RAM byte-lane enables
o_mem_din  out  32  to RAM write data
i_mem_dout  in  32  from RAM, valid one cycle after address

Behaviour:
- Clocking and reset: single clock i_clk. i_rst is synchronous, active-high.
- Reset values:
  - all o_* valid, grant and error flags 0; o_locked 0;
  - o_mem_we 0, o_mem_size 0;
  - state SHARED, fairness counter 0, response tag NONE.
- Datapath:
  - Request-side outputs (gnt, mem_addr, mem_we, mem_size, mem_din) are combinational from the request inputs and the current state.
  - At most one grant per cycle; a request is accepted only in the cycle its gnt is high.
- Grant in SHARED:
  - The debug request wins.
  - Exception: fetch wins when it is pending and the fairness counter equals FAIR_LIMIT.
- Fairness counter:
  - Increments on each debug grant while i_f_req is high.
  - Clears on any fetch grant, or when i_f_req is low.
  - Saturates at FAIR_LIMIT.
- Grant in DRAIN and LOCKED: fetch is never granted; debug is granted whenever it requests.
- Response tag:
  - Registered each cycle: FETCH, DEBUG_RD, DEBUG_WR, DEBUG_ERR or NONE.
  - Next cycle:
    - FETCH: o_f_rvalid = 1, o_f_rdata = i_mem_dout.
    - DEBUG_RD: o_d_rvalid = 1, o_d_rdata = i_mem_dout.
    - DEBUG_WR: o_d_rvalid = 1, rdata 0.
    - DEBUG_ERR: o_d_rvalid = 1, o_d_err = 1, rdata 0.
  - Latency is exactly 1 cycle. Responses have no backpressure.
- Writes:
  - Accepted only with i_d_addr[1:0] == 0; they drive o_mem_we = 1 and o_mem_size = i_d_be.
  - A write with a nonzero offset is still granted but drives o_mem_we = 0 and returns DEBUG_ERR.
  - o_mem_we is never high without o_d_gnt.
- Read-after-write to the same word in consecutive cycles returns the new data.
- Flush:
  - i_f_flush in the cycle a FETCH response is due suppresses o_f_rvalid.
  - i_f_flush in the same cycle as a fetch grant kills that response next cycle.
  - Flush has no effect on debug responses.
- Lock FSM:
  - SHARED -> DRAIN when i_d_lock = 1.
  - DRAIN -> LOCKED once the tag is not FETCH (at most one cycle).
  - LOCKED -> SHARED when i_d_lock = 0.
  - DRAIN -> SHARED if i_d_lock drops while in DRAIN.
  - o_locked = 1 only in LOCKED.
- Simultaneous requests in a cycle where no grant is possible: none exist, since either fetch or debug is always grantable.
- Reset mid-operation: a pending response is dropped (no rvalid in the next cycle) and the lock is released.

Test Plan:
- Fetch only: i_f_req with addr 0x0, 0x4, 0x6 on back-to-back cycles -> o_f_gnt every cycle; o_f_rvalid each following cycle with i_mem_dout passthrough; o_mem_we = 0 throughout.
- Contention with FAIR_LIMIT = 4: both requesters held high -> 4 debug grants, 1 fetch grant, repeating; no cycle with both grants high.
- Debug write then read: write 0xDEADBEEF, be = 0xF, addr 0x100, then read addr 0x100 -> write ack rvalid with rdata 0; read returns 0xDEADBEEF. Write with be = 0x3 to addr 0x102 -> o_d_err = 1, o_mem_we = 0.
- Lock: raise i_d_lock while a fetch response is in flight -> that response is delivered; o_locked rises within 2 cycles; fetch is never granted while locked; dropping i_d_lock -> fetch granted the next cycle.
- Flush: i_f_flush in the cycle a FETCH response is due -> o_f_rvalid = 0, and a debug response in the same cycle is unaffected.
- Reset: assert i_rst for one cycle with both responses pending -> no rvalid afterward; o_locked = 0; fairness restarts at 0.

Source files
------------

// File: rtl/imem_port_arbiter_if.sv
// Bus bundle between the instruction-memory arbiter and its neighbours:
// the fetch port, the debug/loader port and the single-port RAM.
// The arbiter takes the slave view; whoever drives requests and models
// the RAM takes the master view.
interface imem_port_arbiter_if #(
  parameter int IMEM_ADDR_WIDTH = 14
);
  // Fetch port (read-only)
  logic                       i_f_req;
  logic [IMEM_ADDR_WIDTH-1:0] i_f_addr;
  logic                       o_f_gnt;
  logic                       i_f_flush;
  logic                       o_f_rvalid;
  logic [31:0]                o_f_rdata;

  // Debug / program-loader port (read/write)
  logic                       i_d_req;
  logic                       i_d_we;
  logic [3:0]                 i_d_be;
  logic [IMEM_ADDR_WIDTH-1:0] i_d_addr;
  logic [31:0]                i_d_wdata;
  logic                       o_d_gnt;
  logic                       o_d_rvalid;
  logic [31:0]                o_d_rdata;
  logic                       o_d_err;
  logic                       i_d_lock;
  logic                       o_locked;

  // RAM port
  logic [IMEM_ADDR_WIDTH-1:0] o_mem_addr;
  logic                       o_mem_we;
  logic [3:0]                 o_mem_size;
  logic [31:0]                o_mem_din;
  logic [31:0]                i_mem_dout;

  modport slave (
    input  i_f_req, i_f_addr, i_f_flush,
    output o_f_gnt, o_f_rvalid, o_f_rdata,
    input  i_d_req, i_d_we, i_d_be, i_d_addr, i_d_wdata, i_d_lock,
    output o_d_gnt, o_d_rvalid, o_d_rdata, o_d_err, o_locked,
    output o_mem_addr, o_mem_we, o_mem_size, o_mem_din,
    input  i_mem_dout
  );

  modport master (
    output i_f_req, i_f_addr, i_f_flush,
    input  o_f_gnt, o_f_rvalid, o_f_rdata,
    output i_d_req, i_d_we, i_d_be, i_d_addr, i_d_wdata, i_d_lock,
    input  o_d_gnt, o_d_rvalid, o_d_rdata, o_d_err, o_locked,
    input  o_mem_addr, o_mem_we, o_mem_size, o_mem_din,
    output i_mem_dout
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Instruction-memory port arbiter. Shares one single-port RAM between the
// core fetch unit and the debug/program-loader port. Grants are decided
// combinationally each cycle; a one-entry response tag remembers who owns
// the read data the RAM returns on the following cycle. A small lock FSM
// lets the loader take the memory exclusively while it rewrites code.
module imem_port_arbiter #(
  parameter int IMEM_ADDR_WIDTH = 14,
  parameter int FAIR_LIMIT      = 4
) (
  input logic                i_clk,
  input logic                i_rst,
  imem_port_arbiter_if.slave bus
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = (FAIR_LIMIT < 1) ? 1 : $clog2(FAIR_LIMIT + 1);
  localparam logic [CNT_W-1:0] FAIR_MAX = CNT_W'(FAIR_LIMIT);

  typedef enum logic [1:0] {
    ST_SHARED,
    ST_DRAIN,
    ST_LOCKED
  } state_t;

  typedef enum logic [2:0] {
    TAG_NONE,
    TAG_FETCH,
    TAG_DEBUG_RD,
    TAG_DEBUG_WR,
    TAG_DEBUG_ERR
  } tag_t;

  state_t                     state_q;
  state_t                     state_d;
  tag_t                       tag_p0;
  tag_t                       tag_p1;
  logic [CNT_W-1:0]           fair_cnt_q;
  logic [CNT_W-1:0]           fair_cnt_d;
  logic                       fair_hit;
  logic                       f_gnt;
  logic                       d_gnt;
  logic                       d_aligned;
  logic                       wr_ok;
  logic [IMEM_ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_W-1:0]          d_rdata;

  // Fetch has been starved for FAIR_LIMIT debug grants in a row.
  assign fair_hit  = (fair_cnt_q == FAIR_MAX);
  assign d_aligned = (bus.i_d_addr[1:0] == 2'b00);

  // Pick at most one requester; fetch is shut out whenever the loader is
  // draining or holds the lock. Nothing is accepted while reset is held.
  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!i_rst) begin
      if (state_q == ST_SHARED) begin
        if (bus.i_f_req && fair_hit) begin
          f_gnt = 1'b1;
        end else if (bus.i_d_req) begin
          d_gnt = 1'b1;
        end else begin
          f_gnt = bus.i_f_req;
        end
      end else begin
        d_gnt = bus.i_d_req;
      end
    end
  end

  // Misaligned writes still take the port (so they get an error response)
  // but never reach the RAM write enable.
  assign wr_ok    = d_gnt & bus.i_d_we & d_aligned;
  assign mem_addr = d_gnt ? bus.i_d_addr : bus.i_f_addr;

  assign bus.o_f_gnt    = f_gnt;
  assign bus.o_d_gnt    = d_gnt;
  assign bus.o_mem_addr = mem_addr;
  assign bus.o_mem_we   = wr_ok;
  assign bus.o_mem_size = wr_ok ? bus.i_d_be : 4'h0;
  assign bus.o_mem_din  = bus.i_d_wdata;

  // Starvation counter: counts debug wins while fetch keeps asking,
  // restarts once fetch is served or stops asking.
  always_comb begin
    fair_cnt_d = fair_cnt_q;
    if (!bus.i_f_req || f_gnt) begin
      fair_cnt_d = '0;
    end else if (d_gnt && !fair_hit) begin
      fair_cnt_d = fair_cnt_q + 1'b1;
    end
  end

  // Classify this cycle's accepted request; a fetch flushed in its own
  // grant cycle is forgotten immediately.
  always_comb begin
    tag_p0 = TAG_NONE;
    if (f_gnt) begin
      tag_p0 = bus.i_f_flush ? TAG_NONE : TAG_FETCH;
    end else if (d_gnt) begin
      if (!bus.i_d_we) begin
        tag_p0 = TAG_DEBUG_RD;
      end else if (d_aligned) begin
        tag_p0 = TAG_DEBUG_WR;
      end else begin
        tag_p0 = TAG_DEBUG_ERR;
      end
    end
  end

  // Lock FSM next state: DRAIN waits out a fetch response still in flight
  // so the loader never sees the RAM while fetch data is being returned.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_SHARED: begin
        if (bus.i_d_lock) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!bus.i_d_lock) begin
          state_d = ST_SHARED;
        end else if (tag_p1 != TAG_FETCH) begin
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (!bus.i_d_lock) state_d = ST_SHARED;
      end
      default: state_d = ST_SHARED;
    endcase
  end

  // Stage p0 -> p1: register lock state, fairness count and response tag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_SHARED;
      fair_cnt_q <= '0;
      tag_p1     <= TAG_NONE;
    end else begin
      state_q    <= state_d;
      fair_cnt_q <= fair_cnt_d;
      tag_p1     <= tag_p0;
    end
  end

  // Stage p1: RAM data returns now; steer it by the tag. A late flush only
  // kills the fetch side, and reset drops whatever was pending.
  assign d_rdata = (tag_p1 == TAG_DEBUG_RD) ? bus.i_mem_dout : '0;

  assign bus.o_f_rvalid = !i_rst && (tag_p1 == TAG_FETCH) && !bus.i_f_flush;
  assign bus.o_f_rdata  = bus.i_mem_dout;
  assign bus.o_d_rvalid = !i_rst && ((tag_p1 == TAG_DEBUG_RD) ||
                                     (tag_p1 == TAG_DEBUG_WR) ||
                                     (tag_p1 == TAG_DEBUG_ERR));
  assign bus.o_d_err    = !i_rst && (tag_p1 == TAG_DEBUG_ERR);
  assign bus.o_d_rdata  = d_rdata;
  assign bus.o_locked   = !i_rst && (state_q == ST_LOCKED);

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed scenarios followed by a random run,
// every cycle compared against a transaction-level model of the arbiter
// and a shadow copy of the memory contents.
module tb_imem_port_arbiter;

  localparam int AW    = 14;
  localparam int FL    = 4;
  localparam int WORDS = 1 << (AW - 2);

  // response kinds and ownership modes of the reference model
  localparam int K_NONE = 0, K_F = 1, K_RD = 2, K_WR = 3, K_ERR = 4;
  localparam int M_SH = 0, M_DR = 1, M_LK = 2;

  logic i_clk = 1'b0;
  logic i_rst;

  imem_port_arbiter_if #(.IMEM_ADDR_WIDTH(AW)) bus ();

  imem_port_arbiter #(.IMEM_ADDR_WIDTH(AW), .FAIR_LIMIT(FL)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram    [WORDS];
  logic [31:0] shadow [WORDS];

  int          m_mode;
  int          m_streak;
  int          m_pend;
  logic [31:0] m_pend_data;

  logic          s_f_gnt, s_d_gnt, s_f_rvalid, s_d_rvalid, s_d_err, s_locked, s_mem_we;
  logic [31:0]   s_f_rdata, s_d_rdata, s_mem_din;
  logic [AW-1:0] s_mem_addr;
  logic [3:0]    s_mem_size;

  int fcnt, dcnt, both;

  function automatic logic [31:0] pat(input int w);
    return (32'(w) * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic fr, input logic [AW-1:0] fa, input logic fl,
                       input logic dr, input logic dw, input logic [3:0] be,
                       input logic [AW-1:0] da, input logic [31:0] wd, input logic lk);
    bus.i_f_req   = fr;
    bus.i_f_addr  = fa;
    bus.i_f_flush = fl;
    bus.i_d_req   = dr;
    bus.i_d_we    = dw;
    bus.i_d_be    = be;
    bus.i_d_addr  = da;
    bus.i_d_wdata = wd;
    bus.i_d_lock  = lk;
  endtask

  task automatic idle(input logic lk);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'h0, '0, 32'h0, lk);
  endtask

  // One clock: check outputs mid-cycle against the model, advance the
  // model, then let the RAM model react to the clock edge.
  task automatic step();
    logic          rst, ef, ed, alig, ewe, efrv, edrv, ederr, elk;
    logic [3:0]    esize;
    logic [31:0]   edrd;
    logic [AW-1:0] ga;
    int            nmode;
    @(negedge i_clk);
    rst  = i_rst;
    ef   = 1'b0;
    ed   = 1'b0;
    alig = (bus.i_d_addr[1:0] == 2'b00);
    if (rst) begin
      ef = 1'b0;
    end else if (m_mode != M_SH) begin
      ed = bus.i_d_req;
    end else if (bus.i_f_req && m_streak >= FL) begin
      ef = 1'b1;
    end else if (bus.i_d_req) begin
      ed = 1'b1;
    end else begin
      ef = bus.i_f_req;
    end
    ewe   = ed && bus.i_d_we && alig;
    esize = ewe ? bus.i_d_be : 4'h0;
    ga    = ed ? bus.i_d_addr : bus.i_f_addr;
    efrv  = !rst && (m_pend == K_F) && !bus.i_f_flush;
    edrv  = !rst && (m_pend >= K_RD);
    ederr = !rst && (m_pend == K_ERR);
    edrd  = (m_pend == K_RD) ? m_pend_data : 32'h0;
    elk   = !rst && (m_mode == M_LK);

    s_f_gnt    = bus.o_f_gnt;
    s_d_gnt    = bus.o_d_gnt;
    s_f_rvalid = bus.o_f_rvalid;
    s_f_rdata  = bus.o_f_rdata;
    s_d_rvalid = bus.o_d_rvalid;
    s_d_rdata  = bus.o_d_rdata;
    s_d_err    = bus.o_d_err;
    s_locked   = bus.o_locked;
    s_mem_we   = bus.o_mem_we;
    s_mem_addr = bus.o_mem_addr;
    s_mem_size = bus.o_mem_size;
    s_mem_din  = bus.o_mem_din;

    chk("f_gnt", 32'(s_f_gnt), 32'(ef));
    chk("d_gnt", 32'(s_d_gnt), 32'(ed));
    chk("mem_we", 32'(s_mem_we), 32'(ewe));
    chk("mem_size", 32'(s_mem_size), 32'(esize));
    if (ef || ed) chk("mem_addr", 32'(s_mem_addr), 32'(ga));
    if (ewe) chk("mem_din", s_mem_din, bus.i_d_wdata);
    chk("f_rvalid", 32'(s_f_rvalid), 32'(efrv));
    if (efrv) chk("f_rdata", s_f_rdata, m_pend_data);
    chk("d_rvalid", 32'(s_d_rvalid), 32'(edrv));
    chk("d_err", 32'(s_d_err), 32'(ederr));
    if (edrv) chk("d_rdata", s_d_rdata, edrd);
    chk("locked", 32'(s_locked), 32'(elk));

    if (rst) begin
      m_mode   = M_SH;
      m_streak = 0;
      m_pend   = K_NONE;
    end else begin
      nmode = m_mode;
      if (m_mode == M_SH) nmode = bus.i_d_lock ? M_DR : M_SH;
      else if (!bus.i_d_lock) nmode = M_SH;
      else if (m_mode == M_DR && m_pend != K_F) nmode = M_LK;
      m_mode = nmode;
      if (!bus.i_f_req || ef) m_streak = 0;
      else if (ed && m_streak < FL) m_streak = m_streak + 1;
      if (ef) m_pend = bus.i_f_flush ? K_NONE : K_F;
      else if (ed) m_pend = !bus.i_d_we ? K_RD : (alig ? K_WR : K_ERR);
      else m_pend = K_NONE;
      m_pend_data = shadow[ga[AW-1:2]];
      if (ewe)
        for (int b = 0; b < 4; b++)
          if (bus.i_d_be[b]) shadow[ga[AW-1:2]][8*b +: 8] = bus.i_d_wdata[8*b +: 8];
    end

    @(posedge i_clk);
    #1;
    if (s_mem_we)
      for (int b = 0; b < 4; b++)
        if (s_mem_size[b]) ram[s_mem_addr[AW-1:2]][8*b +: 8] = s_mem_din[8*b +: 8];
    bus.i_mem_dout = ram[s_mem_addr[AW-1:2]];
  endtask

  initial begin
    logic lock_r;
    for (int i = 0; i < WORDS; i++) begin
      ram[i]    = pat(i);
      shadow[i] = pat(i);
    end
    bus.i_mem_dout = 32'h0;
    m_mode      = M_SH;
    m_streak    = 0;
    m_pend      = K_NONE;
    m_pend_data = 32'h0;

    // reset
    i_rst = 1'b1;
    idle(1'b0);
    step();
    step();
    i_rst = 1'b0;
    step();
    chk("rst_locked", 32'(s_locked), 32'h0);
    chk("rst_f_rvalid", 32'(s_f_rvalid), 32'h0);
    chk("rst_d_rvalid", 32'(s_d_rvalid), 32'h0);

    // fetch only, back to back, including an unaligned address
    drive(1'b1, 14'h0000, 1'b0, 1'b0, 1'b0, 4'h0, '0, 32'h0, 1'b0);
    step();
    drive(1'b1, 14'h0004, 1'b0, 1'b0, 1'b0, 4'h0, '0, 32'h0, 1'b0);
    step();
    chk("fo_rdata0", s_f_rdata, pat(0));
    drive(1'b1, 14'h0006, 1'b0, 1'b0, 1'b0, 4'h0, '0, 32'h0, 1'b0);
    step();
    chk("fo_rdata4", s_f_rdata, pat(1));
    idle(1'b0);
    step();
    chk("fo_rvalid6", 32'(s_f_rvalid), 32'h1);
    chk("fo_rdata6", s_f_rdata, pat(1));

    // contention: 4 debug grants then 1 fetch grant, repeating
    fcnt = 0; dcnt = 0; both = 0;
    drive(1'b1, 14'h0010, 1'b0, 1'b1, 1'b0, 4'h0, 14'h0020, 32'h0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step();
      fcnt += int'(s_f_gnt);
      dcnt += int'(s_d_gnt);
      both += int'(s_f_gnt && s_d_gnt);
    end
    chk("cont_fetch_cnt", 32'(fcnt), 32'd3);
    chk("cont_debug_cnt", 32'(dcnt), 32'd12);
    chk("cont_both", 32'(both), 32'd0);

    // debug write, read back, misaligned write
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 4'hF, 14'h0100, 32'hDEADBEEF, 1'b0);
    step();
    chk("wr_mem_we", 32'(s_mem_we), 32'h1);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 4'h0, 14'h0100, 32'h0, 1'b0);
    step();
    chk("wr_ack_valid", 32'(s_d_rvalid), 32'h1);
    chk("wr_ack_rdata", s_d_rdata, 32'h0);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 4'h3, 14'h0102, 32'h12345678, 1'b0);
    step();
    chk("rd_back", s_d_rdata, 32'hDEADBEEF);
    chk("err_gnt", 32'(s_d_gnt), 32'h1);
    chk("err_mem_we", 32'(s_mem_we), 32'h0);
    idle(1'b0);
    step();
    chk("err_flag", 32'(s_d_err), 32'h1);
    chk("err_rdata", s_d_rdata, 32'h0);

    // lock raised while a fetch response is in flight
    drive(1'b1, 14'h0040, 1'b0, 1'b0, 1'b0, 4'h0, '0, 32'h0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'h0, '0, 32'h0, 1'b1);
    step();
    chk("lock_inflight", 32'(s_f_rvalid), 32'h1);
    chk("lock_inflight_d", s_f_rdata, pat(16));
    drive(1'b1, 14'h0044, 1'b0, 1'b0, 1'b0, 4'h0, '0, 32'h0, 1'b1);
    step();
    step();
    chk("lock_rise", 32'(s_locked), 32'h1);
    fcnt = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 14'h0044, 1'b0, 1'(i % 2), 1'b0, 4'h0, 14'h0100, 32'h0, 1'b1);
      step();
      fcnt += int'(s_f_gnt);
    end
    chk("lock_no_fetch", 32'(fcnt), 32'h0);
    drive(1'b1, 14'h0044, 1'b0, 1'b0, 1'b0, 4'h0, '0, 32'h0, 1'b0);
    step();
    step();
    chk("unlock_fetch", 32'(s_f_gnt), 32'h1);

    // flush on the response cycle, debug response alongside
    drive(1'b1, 14'h0008, 1'b0, 1'b0, 1'b0, 4'h0, '0, 32'h0, 1'b0);
    step();
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0, 4'h0, 14'h0100, 32'h0, 1'b0);
    step();
    chk("flush_due", 32'(s_f_rvalid), 32'h0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 4'h0, '0, 32'h0, 1'b0);
    step();
    chk("flush_dbg_valid", 32'(s_d_rvalid), 32'h1);
    chk("flush_dbg_rdata", s_d_rdata, 32'hDEADBEEF);
    // flush in the grant cycle itself
    drive(1'b1, 14'h000C, 1'b1, 1'b0, 1'b0, 4'h0, '0, 32'h0, 1'b0);
    step();
    idle(1'b0);
    step();
    chk("flush_at_gnt", 32'(s_f_rvalid), 32'h0);

    // reset while locked with a debug read pending
    idle(1'b1);
    step();
    step();
    step();
    chk("pre_rst_locked", 32'(s_locked), 32'h1);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 4'h0, 14'h0100, 32'h0, 1'b1);
    step();
    i_rst = 1'b1;
    idle(1'b1);
    step();
    chk("rst_drop_resp", 32'(s_d_rvalid), 32'h0);
    i_rst = 1'b0;
    idle(1'b0);
    step();
    chk("rst_no_resp", 32'(s_d_rvalid), 32'h0);
    chk("rst_unlocked", 32'(s_locked), 32'h0);
    dcnt = 0;
    drive(1'b1, 14'h0010, 1'b0, 1'b1, 1'b0, 4'h0, 14'h0020, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      dcnt += int'(s_d_gnt);
    end
    chk("rst_fair_dbg", 32'(dcnt), 32'd4);
    step();
    chk("rst_fair_fetch", 32'(s_f_gnt), 32'h1);

    // random traffic against the model
    lock_r = 1'b0;
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 15) == 0) lock_r = !lock_r;
      i_rst = ($urandom_range(0, 59) == 0);
      drive($urandom_range(0, 9) < 7, AW'($urandom_range(0, 63)),
            $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) < 4, 4'($urandom), AW'($urandom_range(0, 63)),
            $urandom, lock_r);
      step();
    end
    i_rst = 1'b0;
    idle(1'b0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
